psum_accum_drain: RTL

- Downstream stage of the PE array. Consumes the output partial-sum stream and accumulates it across multiple channel passes.
- Multiple passes occur when the input channel count (q*r) exceeds what one array mapping covers.
- After the last pass, drains the finished ofmap values to the ofmap writeback through a valid/ready handshake.
- Accumulation is modulo 2^DATA_W, matching the golden convolution model.

---
 rtl/psum_accum_drain.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/psum_accum_drain.sv
// Partial-sum accumulator: sums num_pass passes of num_out psums per index, then drains
// the ofmap words over a valid/ready handshake. Optional macro PSUM_ACCUM_RELU_EN clamps negative drained words to zero.
module psum_accum_drain #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_out,
    input  logic [3:0]        num_pass,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   idx_r;
    logic [3:0]          pass_cnt_r;
    logic [ADDR_W:0]     num_out_r;
    logic [3:0]          num_pass_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                in_acc_s;
    logic                last_idx_s;
    logic                last_pass_s;
    logic [ADDR_W-1:0]   idx_inc_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic [DATA_W-1:0]   first_rd_s;
    logic [DATA_W-1:0]   next_rd_s;

    // Word presented to the writeback; negative sums are clamped only when the RELU build is selected.
    function automatic logic [DATA_W-1:0] drain_word(input logic [DATA_W-1:0] v);
`ifdef PSUM_ACCUM_RELU_EN
        if (v[DATA_W-1]) begin
            return {DATA_W{1'b0}};
        end else begin
            return v;
        end
`else
        return v;
`endif
    endfunction

    // Handshake decode, accumulate datapath and next drain-word read.
    always_comb begin
        in_acc_s    = (state_r == ACCUM) && in_valid;
        last_idx_s  = ({1'b0, idx_r} == (num_out_r - {{ADDR_W{1'b0}}, 1'b1}));
        last_pass_s = (pass_cnt_r == (num_pass_r - 4'd1));
        idx_inc_s   = idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (pass_cnt_r == 4'd0) begin
            wr_data_s = in_data;
        end else begin
            wr_data_s = mem_r[idx_r] + in_data;
        end
        // With num_out==1 the final write and the first drain read hit the same entry.
        if (idx_r == {ADDR_W{1'b0}}) begin
            first_rd_s = wr_data_s;
        end else begin
            first_rd_s = mem_r[{ADDR_W{1'b0}}];
        end
        next_rd_s = mem_r[idx_inc_s];
    end

    // Accumulation buffer; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (in_acc_s) begin
            mem_r[idx_r] <= wr_data_s;
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            idx_r      <= {ADDR_W{1'b0}};
            pass_cnt_r <= 4'd0;
            num_out_r  <= {(ADDR_W+1){1'b0}};
            num_pass_r <= 4'd0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= {DATA_W{1'b0}};
            out_addr   <= {ADDR_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        num_out_r  <= num_out;
                        num_pass_r <= num_pass;
                        idx_r      <= {ADDR_W{1'b0}};
                        pass_cnt_r <= 4'd0;
                        if ((num_out == {(ADDR_W+1){1'b0}}) || (num_pass == 4'd0)) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r  <= ACCUM;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_acc_s) begin
                        if (last_idx_s) begin
                            idx_r      <= {ADDR_W{1'b0}};
                            pass_cnt_r <= pass_cnt_r + 4'd1;
                            if (last_pass_s) begin
                                state_r   <= DRAIN;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                                out_addr  <= {ADDR_W{1'b0}};
                                out_data  <= drain_word(first_rd_s);
                            end
                        end else begin
                            idx_r <= idx_inc_s;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (last_idx_s) begin
                            state_r   <= DONE;
                            idx_r     <= {ADDR_W{1'b0}};
                            out_valid <= 1'b0;
                            out_addr  <= {ADDR_W{1'b0}};
                            out_data  <= {DATA_W{1'b0}};
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx_r    <= idx_inc_s;
                            out_addr <= idx_inc_s;
                            out_data <= drain_word(next_rd_s);
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
